// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        divide request, honoured only in IDLE
//   dividend     numerator, captured on the accepted start edge
//   divisor      denominator, captured on the accepted start edge
//   busy         high while iterating
//   done         one-cycle completion pulse
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   div_by_zero  registered divide-by-zero flag
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] d_q, v_q, quot_q, rem_q;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    cnt_q;
    logic             dbz_q;
    logic [WIDTH:0]   r_shift, t_diff, r_d;
    logic [WIDTH-1:0] d_d;
    // R stays below V, so the WIDTH+1-bit trial difference never wraps and its MSB is the sign.
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], d_q[WIDTH-1]};
        t_diff  = r_shift - {1'b0, v_q};
        r_d     = t_diff[WIDTH] ? r_shift : t_diff;
        d_d     = {d_q[WIDTH-2:0], ~t_diff[WIDTH]};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (divisor == '0) begin
                        state_q <= DONE;
                        quot_q  <= '1;
                        rem_q   <= dividend;
                        dbz_q   <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        d_q     <= dividend;
                        v_q     <= divisor;
                        r_q     <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    d_q   <= d_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        quot_q  <= d_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n, start, busy, done, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    int           checks = 0;
    int           errors = 0;
    bit           seen;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        int s;
        s = $urandom_range(0, 9);
        return (s == 0) ? {W{1'b0}} : (s == 1) ? {W{1'b1}} : W'($urandom);
    endfunction

    // Issues one divide from IDLE and checks latency, busy span, results and the one-cycle done pulse.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [W-1:0] eq, er, prev_q;
        logic         edz;
        int           n, nbusy, exp_lat;
        edz     = (b == 0);
        eq      = edz ? {W{1'b1}} : a / b;
        er      = edz ? a : a % b;
        exp_lat = edz ? 0 : W;
        prev_q  = quotient;
        start = 1'b1; dividend = a; divisor = b;
        step();
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        n = 0; nbusy = 0;
        while (!done && n < 4 * W) begin
            if (busy) nbusy++;
            if (n == 3) begin
                chk("hold_q_during_run", quotient, prev_q);
                start = inject; dividend = 9; divisor = 3;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("latency", n, exp_lat);
        chk("busy_cycles", nbusy, exp_lat);
        chk("done", done, 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
        step();
        chk("done_one_cycle", done, 0);
        chk("quotient_hold", quotient, eq);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        step();
        do_div(100, 7, 0);
        do_div(255, 1, 0);
        do_div(5, 9, 0);
        do_div(42, 0, 0);
        do_div(200, 16, 0);
        do_div(200, 13, 1);
        start = 1'b1; dividend = 77; divisor = 5;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        do_div(77, 5, 0);
        for (int i = 0; i < 1000; i++) do_div(pick(), pick(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
